// File: rtl/note_player.sv
// note_player: sequences one note at a time, counting beats and muxing sine-reader
// samples or silence onto the output sample stream.
module note_player (
   input  logic        clk,
   input  logic        reset,
   input  logic        play_enable,
   input  logic [5:0]  note,
   input  logic [5:0]  duration,
   input  logic        load_new_note,
   input  logic        beat,
   input  logic        generate_next_sample,
   output logic [5:0]  rom_addr,
   input  logic [19:0] rom_step,
   output logic [19:0] step_size,
   output logic        sine_generate_next,
   input  logic        sine_sample_ready,
   input  logic [15:0] sine_sample,
   output logic [15:0] sample_out,
   output logic        new_sample_ready,
   output logic        done_with_note
);
   localparam logic IDLE = 1'b0;
   localparam logic PLAYING = 1'b1;
   logic       state;
   logic [5:0] note_reg;
   logic [5:0] beats_left;
   logic       audible;
   logic       beat_ok;
   logic       zero_req;
   logic       sine_take;
   assign rom_addr = note;
   assign audible = (state == PLAYING) && (note_reg != 6'd0);
   assign sine_generate_next = !reset && generate_next_sample && play_enable && audible;
   assign beat_ok = (state == PLAYING) && play_enable && beat && !load_new_note;
   // Silence is answered locally whenever the sine reader would not be asked.
   assign zero_req = generate_next_sample && !(audible && play_enable);
   assign sine_take = sine_sample_ready && audible;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         note_reg <= 6'd0;
         beats_left <= 6'd0;
         step_size <= 20'd0;
         sample_out <= 16'd0;
         new_sample_ready <= 1'b0;
         done_with_note <= 1'b0;
      end else begin
         done_with_note <= 1'b0;
         new_sample_ready <= zero_req || sine_take;
         if (zero_req) sample_out <= 16'd0;
         else if (sine_take) sample_out <= sine_sample;
         if (load_new_note) begin
            note_reg <= note;
            beats_left <= duration;
            step_size <= rom_step;
            state <= (duration != 6'd0) ? PLAYING : IDLE;
            done_with_note <= (duration == 6'd0);
         end else if (beat_ok) begin
            beats_left <= beats_left - 6'd1;
            if (beats_left == 6'd1) begin
               state <= IDLE;
               done_with_note <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed and randomized checks of note_player against a
// rule-level reference model of notes, beats and samples.
module tb_note_player;
   logic        clk = 1'b0;
   logic        reset, play_enable, load_new_note, beat, generate_next_sample;
   logic [5:0]  note, duration, rom_addr;
   logic [19:0] rom_step, step_size;
   logic        sine_generate_next, sine_sample_ready, new_sample_ready, done_with_note;
   logic [15:0] sine_sample, sample_out;
   int errors = 0;
   int checks = 0;
   bit          m_play;
   int          m_note, m_beats;
   logic [19:0] m_step;
   logic [15:0] m_sample;
   bit          m_ready, m_done;

   note_player dut (
      .clk(clk), .reset(reset), .play_enable(play_enable), .note(note),
      .duration(duration), .load_new_note(load_new_note), .beat(beat),
      .generate_next_sample(generate_next_sample), .rom_addr(rom_addr),
      .rom_step(rom_step), .step_size(step_size), .sine_generate_next(sine_generate_next),
      .sine_sample_ready(sine_sample_ready), .sine_sample(sine_sample),
      .sample_out(sample_out), .new_sample_ready(new_sample_ready),
      .done_with_note(done_with_note)
   );

   always #5 clk = ~clk;

   // Reference: applies the player's rules to the inputs present at the edge.
   task automatic advance();
      bit zero, take, silent;
      silent = !m_play || !play_enable || m_note == 0;
      zero = generate_next_sample && silent;
      take = sine_sample_ready && m_play && m_note != 0;
      @(posedge clk);
      #1;
      if (reset) begin
         m_play = 0; m_note = 0; m_beats = 0; m_step = 0; m_sample = 0; m_ready = 0; m_done = 0;
      end else begin
         m_ready = zero || take;
         if (zero) m_sample = 16'h0000;
         else if (take) m_sample = sine_sample;
         m_done = 0;
         if (load_new_note) begin
            m_note = int'(note);
            m_beats = int'(duration);
            m_step = rom_step;
            m_play = duration > 0;
            m_done = duration == 0;
         end else if (beat && m_play && play_enable) begin
            m_beats = m_beats - 1;
            if (m_beats == 0) begin
               m_play = 0;
               m_done = 1;
            end
         end
      end
      load_new_note = 0; beat = 0; generate_next_sample = 0; sine_sample_ready = 0;
   endtask

   function automatic bit exp_sine_gen();
      return !reset && generate_next_sample && play_enable && m_play && m_note != 0;
   endfunction

   task automatic load(input int n, input int d, input logic [19:0] s);
      note = 6'(n); duration = 6'(d); rom_step = s; load_new_note = 1;
      advance();
   endtask

   task automatic test_reset();
      reset = 1; load_new_note = 1; beat = 1; generate_next_sample = 1; note = 6'd9;
      duration = 6'd5; rom_step = 20'hABCDE; play_enable = 1; sine_sample_ready = 1;
      #1;
      checks++;
      if (sine_generate_next !== 1'b0) begin errors++; $display("FAIL reset_sine_gen got %b exp 0", sine_generate_next); end
      advance();
      advance();
      checks++;
      if ({sample_out, new_sample_ready, done_with_note, step_size} !== '0)
         begin errors++; $display("FAIL reset_outputs got %h %b %b %h exp 0", sample_out, new_sample_ready, done_with_note, step_size); end
      reset = 0;
   endtask

   task automatic test_note_duration();
      load(12, 3, 20'h00400);
      checks++;
      if (step_size !== 20'h00400) begin errors++; $display("FAIL dur_step got %h exp 00400", step_size); end
      for (int i = 1; i <= 3; i++) begin
         rom_step = 20'($urandom);
         advance();
         beat = 1;
         advance();
         checks++;
         if (done_with_note !== m_done || done_with_note !== (i == 3))
            begin errors++; $display("FAIL dur_done beat%0d got %b exp %b", i, done_with_note, i == 3); end
         checks++;
         if (step_size !== 20'h00400) begin errors++; $display("FAIL dur_step_hold got %h exp 00400", step_size); end
      end
      advance();
      checks++;
      if (done_with_note !== 1'b0) begin errors++; $display("FAIL dur_done_single got %b exp 0", done_with_note); end
   endtask

   task automatic test_sine_sample();
      load(12, 5, 20'h00400);
      generate_next_sample = 1;
      #1;
      checks++;
      if (sine_generate_next !== 1'b1) begin errors++; $display("FAIL sine_gen got %b exp 1", sine_generate_next); end
      advance();
      sine_sample_ready = 1; sine_sample = 16'h1234;
      advance();
      checks++;
      if (sample_out !== 16'h1234 || new_sample_ready !== 1'b1)
         begin errors++; $display("FAIL sine_sample got %h/%b exp 1234/1", sample_out, new_sample_ready); end
      advance();
      checks++;
      if (sample_out !== 16'h1234 || new_sample_ready !== 1'b0)
         begin errors++; $display("FAIL sine_hold got %h/%b exp 1234/0", sample_out, new_sample_ready); end
      for (int i = 0; i < 4; i++) begin
         sine_sample_ready = 1; sine_sample = 16'($urandom);
         advance();
         checks++;
         if (sample_out !== m_sample || new_sample_ready !== 1'b1)
            begin errors++; $display("FAIL sine_rand got %h/%b exp %h/1", sample_out, new_sample_ready, m_sample); end
      end
   endtask

   task automatic test_rest_note();
      load(0, 2, 20'h00000);
      for (int i = 0; i < 3; i++) begin
         generate_next_sample = 1; sine_sample_ready = 1'($urandom); sine_sample = 16'($urandom | 1);
         #1;
         checks++;
         if (sine_generate_next !== 1'b0) begin errors++; $display("FAIL rest_sine_gen got %b exp 0", sine_generate_next); end
         advance();
         checks++;
         if (sample_out !== 16'h0000 || new_sample_ready !== 1'b1)
            begin errors++; $display("FAIL rest_sample got %h/%b exp 0000/1", sample_out, new_sample_ready); end
      end
      for (int i = 1; i <= 2; i++) begin
         beat = 1;
         advance();
         checks++;
         if (done_with_note !== (i == 2)) begin errors++; $display("FAIL rest_done beat%0d got %b exp %b", i, done_with_note, i == 2); end
      end
   endtask

   task automatic test_pause();
      load(5, 2, 20'h01234);
      play_enable = 0;
      for (int i = 0; i < 4; i++) begin
         beat = 1; generate_next_sample = 1;
         advance();
         checks++;
         if (dut.beats_left !== 6'd2 || done_with_note !== 1'b0 || sample_out !== 16'h0 || new_sample_ready !== 1'b1)
            begin errors++; $display("FAIL pause got beats=%0d done=%b sample=%h rdy=%b exp 2/0/0000/1", dut.beats_left, done_with_note, sample_out, new_sample_ready); end
      end
      play_enable = 1;
      for (int i = 1; i <= 2; i++) begin
         beat = 1;
         advance();
         checks++;
         if (done_with_note !== (i == 2)) begin errors++; $display("FAIL resume_done beat%0d got %b exp %b", i, done_with_note, i == 2); end
      end
   endtask

   task automatic test_load_over_beat();
      load(7, 1, 20'h00777);
      beat = 1;
      load(9, 4, 20'h00999);
      checks++;
      if (done_with_note !== 1'b0 || dut.beats_left !== 6'd4 || step_size !== 20'h00999)
         begin errors++; $display("FAIL load_over_beat got done=%b beats=%0d step=%h exp 0/4/00999", done_with_note, dut.beats_left, step_size); end
      advance();
      checks++;
      if (done_with_note !== 1'b0) begin errors++; $display("FAIL load_over_beat_late got %b exp 0", done_with_note); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset = $urandom_range(0, 59) == 0;
         play_enable = $urandom_range(0, 3) != 0;
         load_new_note = $urandom_range(0, 11) == 0;
         note = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
         duration = 6'($urandom_range(0, 4));
         beat = $urandom_range(0, 2) == 0;
         generate_next_sample = $urandom_range(0, 3) == 0;
         sine_sample_ready = $urandom_range(0, 3) == 0;
         sine_sample = 16'($urandom);
         rom_step = 20'($urandom);
         #1;
         checks++;
         if (sine_generate_next !== exp_sine_gen() || rom_addr !== note)
            begin errors++; $display("FAIL rand_comb cyc%0d got %b/%h exp %b/%h", i, sine_generate_next, rom_addr, exp_sine_gen(), note); end
         advance();
         checks++;
         if (sample_out !== m_sample || new_sample_ready !== m_ready || done_with_note !== m_done || step_size !== m_step)
            begin errors++; $display("FAIL rand_out cyc%0d got %h/%b/%b/%h exp %h/%b/%b/%h", i, sample_out, new_sample_ready, done_with_note, step_size, m_sample, m_ready, m_done, m_step); end
      end
      reset = 0;
   endtask

   initial begin
      test_reset();
      test_note_duration();
      test_sine_sample();
      test_rest_note();
      test_pause();
      test_load_over_beat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
